alu_op_sequencer: RTL

- Issuing end of the ALU control interface: accepts one decoded ALU request per valid/ready handshake.
- Derives the 3-bit ALUControl code, drives registered operands and code to the external combinational ALU, and captures its result.
- Returns result, zero and illegal flags through an output valid/ready handshake.
- Sits between the decode stage and the ALU in the multi-cycle datapath variant of the core.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_op_sequencer_if.sv | 44 ++++
 rtl/alu_decoder.sv | 40 ++++
 rtl/alu_op_sequencer.sv | 120 ++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control definitions: ALUControl codes, ALUOp encodings,
// funct3 selectors and the sequencer state encoding.
package alu_pkg;

   // ALUControl codes understood by the external ALU
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;

   // ALUOp encodings produced by the main decoder
   localparam logic [1:0] ALUOP_MEM    = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
   localparam logic [1:0] ALUOP_RSVD   = 2'b11;

   // funct3 values decoded under ALUOP_FUNCT
   localparam logic [2:0] F3_ADDSUB = 3'b000;
   localparam logic [2:0] F3_AND    = 3'b111;
   localparam logic [2:0] F3_OR     = 3'b110;

   // Sequencer states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } seq_state_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request, ALU and response signals of the ALU op sequencer.
// slave  : the sequencer side.
// master : producer/consumer and external ALU side.
interface alu_op_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [1:0]       in_aluop;
   logic [2:0]       in_funct3;
   logic             in_funct7b5;
   logic             in_op5;

   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [2:0]       alu_control;
   logic [WIDTH-1:0] alu_result;

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic             out_zero;
   logic             out_illegal;

   modport slave (
      input  in_valid, in_a, in_b, in_aluop, in_funct3, in_funct7b5, in_op5,
      output in_ready,
      output alu_a, alu_b, alu_control,
      input  alu_result,
      output out_valid, out_result, out_zero, out_illegal,
      input  out_ready
   );

   modport master (
      output in_valid, in_a, in_b, in_aluop, in_funct3, in_funct7b5, in_op5,
      input  in_ready,
      input  alu_a, alu_b, alu_control,
      output alu_result,
      input  out_valid, out_result, out_zero, out_illegal,
      output out_ready
   );
endinterface

// File: rtl/alu_decoder.sv
// Combinational ALUControl decoder. Unsupported encodings raise illegal_o
// and return ALU_ADD so that nothing downstream sees a stray code.
module alu_decoder
   import alu_pkg::*;
(
   input  logic [1:0] aluop_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7b5_i,
   input  logic       op5_i,
   output logic [2:0] alu_control_o,
   output logic       illegal_o
);

   // Map ALUOp/funct fields onto an ALUControl code
   always_comb begin
      alu_control_o = ALU_ADD;
      illegal_o     = 1'b0;
      case (aluop_i)
         ALUOP_MEM:    alu_control_o = ALU_ADD;
         ALUOP_BRANCH: alu_control_o = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3_i)
               F3_ADDSUB: begin
                  // Only R-type with bit 30 set subtracts; addi never does
                  if ({op5_i, funct7b5_i} == 2'b11) begin
                     alu_control_o = ALU_SUB;
                  end else begin
                     alu_control_o = ALU_ADD;
                  end
               end
               F3_AND:  alu_control_o = ALU_AND;
               F3_OR:   alu_control_o = ALU_OR;
               default: illegal_o     = 1'b1;
            endcase
         end
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues one decoded request at a time to the external ALU: registers the
// operands and ALUControl code, gives the ALU one full cycle to settle,
// captures the result and presents it until the consumer takes it.
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic clk,
   input  logic rst,
   alu_op_sequencer_if.slave bus
);

   seq_state_t       state_q, state_d;
   logic [WIDTH-1:0] alu_a_q, alu_b_q, result_q;
   logic [2:0]       alu_ctrl_q;
   logic             zero_q, illegal_q;

   logic [2:0]       dec_ctrl_s;
   logic             dec_illegal_s;
   logic             in_ready_s, out_valid_s, accept_s;

   alu_decoder u_dec (
      .aluop_i       (bus.in_aluop),
      .funct3_i      (bus.in_funct3),
      .funct7b5_i    (bus.in_funct7b5),
      .op5_i         (bus.in_op5),
      .alu_control_o (dec_ctrl_s),
      .illegal_o     (dec_illegal_s)
   );

   assign accept_s = in_ready_s & bus.in_valid;

   // State register; reset overrides everything and drops any in-flight response
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: illegal requests skip EXEC since there is nothing to capture
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               if (dec_illegal_s) begin
                  state_d = DONE;
               end else begin
                  state_d = EXEC;
               end
            end else begin
               state_d = IDLE;
            end
         end
         EXEC: state_d = DONE;
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs decoded from the current state
   always_comb begin
      in_ready_s  = (state_q == IDLE) && !rst;
      out_valid_s = (state_q == DONE);
   end

   // Operand/code latch on accept and result capture in EXEC; held otherwise
   always_ff @(posedge clk) begin
      if (rst) begin
         alu_a_q    <= {WIDTH{1'b0}};
         alu_b_q    <= {WIDTH{1'b0}};
         alu_ctrl_q <= ALU_ADD;
         result_q   <= {WIDTH{1'b0}};
         zero_q     <= 1'b0;
         illegal_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept_s) begin
                  alu_a_q    <= bus.in_a;
                  alu_b_q    <= bus.in_b;
                  alu_ctrl_q <= dec_ctrl_s;
                  if (dec_illegal_s) begin
                     result_q  <= {WIDTH{1'b0}};
                     zero_q    <= 1'b0;
                     illegal_q <= 1'b1;
                  end
               end
            end
            EXEC: begin
               result_q  <= bus.alu_result;
               zero_q    <= (bus.alu_result == {WIDTH{1'b0}});
               illegal_q <= 1'b0;
            end
            default: begin
               result_q <= result_q;
            end
         endcase
      end
   end

   assign bus.in_ready    = in_ready_s;
   assign bus.out_valid   = out_valid_s;
   assign bus.alu_a       = alu_a_q;
   assign bus.alu_b       = alu_b_q;
   assign bus.alu_control = alu_ctrl_q;
   assign bus.out_result  = result_q;
   assign bus.out_zero    = zero_q;
   assign bus.out_illegal = illegal_q;

endmodule
